// File: rtl/cb_pkg.sv
// Connection block shared parameters and configuration field map.
package cb_pkg;

  localparam int W       = 4;
  localparam int NP      = 4;
  localparam int SELW    = 4;
  localparam int CFG_LEN = NP*W*SELW + NP + 1;

  localparam int SEL_BASE  = 0;
  localparam int MODE_BASE = 64;
  localparam int EN_BIT    = 68;

  function automatic int sel_off(input int p, input int b);
    return SEL_BASE + (p*W + b)*SELW;
  endfunction

endpackage

// File: rtl/cb_out_port.sv
// One output pin group: four 16:1 muxes, enable gate and
// an optional output register.
module cb_out_port
  import cb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NP*W-1:0]   bus,
  input  logic [W*SELW-1:0] sel,
  input  logic              en,
  input  logic              reg_mode,
  output logic [W-1:0]      out_p
);

  logic [W-1:0] r;
  logic [W-1:0] out_d;
  logic [W-1:0] out_q;

  always_comb begin
    r = '0;
    for (int b = 0; b < W; b++) begin
      if (en) r[b] = bus[sel[b*SELW +: SELW]];
    end
    out_d = r;
  end

  always_ff @(posedge clk) begin
    if (!rst) out_q <= '0;
    else      out_q <= out_d;
  end

  assign out_p = reg_mode ? out_q : r;

endmodule

// File: rtl/connection_block.sv
// FPGA connection block: serial config chain plus four
// routed output ports.
module connection_block
  import cb_pkg::*;
(
  input  logic         clb_clk,
  input  logic         rst,
  input  logic         prog_in,
  input  logic         prog_en,
  output logic         prog_out,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic [W-1:0] out4
);

  logic [CFG_LEN-1:0] cfg_d;
  logic [CFG_LEN-1:0] cfg_q;
  logic [NP*W-1:0]    bus;
  logic [W-1:0]       out_w [NP];

  always_comb begin
    cfg_d = cfg_q;
    if (prog_en) cfg_d = {prog_in, cfg_q[CFG_LEN-1:1]};
  end

  // Config is live: the muxes read cfg_q directly, no shadow.
  always_ff @(posedge clb_clk) begin
    if (!rst) cfg_q <= '0;
    else      cfg_q <= cfg_d;
  end

  assign bus      = {in4, in3, in2, in1};
  assign prog_out = cfg_q[0];

  for (genvar p = 0; p < NP; p++) begin : g_port
    cb_out_port u_port (
      .clk      (clb_clk),
      .rst      (rst),
      .bus      (bus),
      .sel      (cfg_q[sel_off(p, 0) +: W*SELW]),
      .en       (cfg_q[EN_BIT]),
      .reg_mode (cfg_q[MODE_BASE+p]),
      .out_p    (out_w[p])
    );
  end

  assign out1 = out_w[0];
  assign out2 = out_w[1];
  assign out3 = out_w[2];
  assign out4 = out_w[3];

endmodule

// File: tb/tb_connection_block.sv
// Self-checking bench: directed cases plus random loads
// checked against a field-map reference model.
module tb_connection_block;

  logic       clb_clk = 1'b0;
  logic       rst = 1'b0;
  logic       prog_in = 1'b0;
  logic       prog_en = 1'b0;
  logic       prog_out;
  logic [3:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic [3:0] out1, out2, out3, out4;

  int n_checks = 0;
  int n_errors = 0;

  logic [68:0] cfg_m;
  logic [3:0]  reg_m [4];

  connection_block dut (
    .clb_clk  (clb_clk),
    .rst      (rst),
    .prog_in  (prog_in),
    .prog_en  (prog_en),
    .prog_out (prog_out),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4)
  );

  always #5 clb_clk = ~clb_clk;

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bus_now();
    return {in4, in3, in2, in1};
  endfunction

  function automatic logic [3:0] route(
    input logic [68:0] c, input logic [15:0] bus, input int p);
    logic [3:0] r;
    logic [3:0] s;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      s = c[(p*4+b)*4 +: 4];
      r[b] = c[68] ? bus[s] : 1'b0;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_out(input int p);
    if (cfg_m[64+p]) return reg_m[p];
    return route(cfg_m, bus_now(), p);
  endfunction

  task automatic tick();
    logic [3:0]  nxt [4];
    logic [68:0] cnxt;
    for (int p = 0; p < 4; p++)
      nxt[p] = rst ? route(cfg_m, bus_now(), p) : 4'h0;
    if (!rst)         cnxt = '0;
    else if (prog_en) cnxt = {prog_in, cfg_m[68:1]};
    else              cnxt = cfg_m;
    @(posedge clb_clk);
    #1;
    cfg_m = cnxt;
    for (int p = 0; p < 4; p++) reg_m[p] = nxt[p];
  endtask

  task automatic do_reset();
    rst = 1'b0;
    prog_en = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic load(input logic [68:0] prog);
    for (int i = 0; i < 69; i++) begin
      prog_en = 1'b1;
      prog_in = prog[i];
      tick();
    end
    prog_en = 1'b0;
    prog_in = 1'b0;
  endtask

  task automatic check_model(input string tag);
    #1;
    chk({tag, "_o1"}, out1, exp_out(0));
    chk({tag, "_o2"}, out2, exp_out(1));
    chk({tag, "_o3"}, out3, exp_out(2));
    chk({tag, "_o4"}, out4, exp_out(3));
    chk({tag, "_po"}, {3'b0, prog_out}, {3'b0, cfg_m[0]});
  endtask

  function automatic logic [68:0] ident(
    input logic en, input logic [3:0] mode);
    logic [68:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*4 +: 4] = 4'(i);
    v[67:64] = mode;
    v[68] = en;
    return v;
  endfunction

  initial begin
    logic [68:0] prog;
    cfg_m = 'x;
    for (int p = 0; p < 4; p++) reg_m[p] = 'x;

    // 1: reset, no program
    in1 = 4'hF; in2 = 4'hF; in3 = 4'hF; in4 = 4'hF;
    do_reset();
    #1;
    chk("rst_o1", out1, 4'h0);
    chk("rst_o2", out2, 4'h0);
    chk("rst_o3", out3, 4'h0);
    chk("rst_o4", out4, 4'h0);
    chk("rst_po", {3'b0, prog_out}, 4'h0);

    // 2: identity, combinational
    load(ident(1'b1, 4'b0000));
    in1 = 4'h3; in2 = 4'hA; in3 = 4'h5; in4 = 4'hC;
    #1;
    chk("id_o1", out1, 4'h3);
    chk("id_o2", out2, 4'hA);
    chk("id_o3", out3, 4'h5);
    chk("id_o4", out4, 4'hC);

    // 3: broadcast from bit 15
    prog = '0;
    for (int i = 0; i < 16; i++) prog[i*4 +: 4] = 4'hF;
    prog[68] = 1'b1;
    do_reset();
    load(prog);
    in1 = 4'h0; in2 = 4'h0; in3 = 4'h0; in4 = 4'h8;
    #1;
    chk("bc1_o1", out1, 4'hF);
    chk("bc1_o4", out4, 4'hF);
    in4 = 4'h0;
    #1;
    chk("bc0_o2", out2, 4'h0);
    chk("bc0_o3", out3, 4'h0);

    // 4: registered mode, one-cycle latency
    do_reset();
    load(ident(1'b1, 4'b1111));
    in1 = 4'h0;
    tick();
    in1 = 4'h6;
    #1;
    chk("reg_pre", out1, 4'h0);
    tick();
    chk("reg_post", out1, 4'h6);
    check_model("reg_m");

    // 5: enable off
    do_reset();
    load(ident(1'b0, 4'b0000));
    for (int k = 0; k < 3; k++) begin
      in1 = 4'($urandom); in2 = 4'($urandom);
      in3 = 4'($urandom); in4 = 4'($urandom);
      #1;
      chk("en0_o1", out1, 4'h0);
      chk("en0_o4", out4, 4'h0);
    end

    // 6: chain propagation and reset mid-load
    do_reset();
    prog = '0;
    prog[0] = 1'b1;
    for (int i = 0; i < 69; i++) begin
      prog_en = 1'b1;
      prog_in = prog[i];
      tick();
      if (i == 67) chk("chain68", {3'b0, prog_out}, 4'h0);
    end
    prog_en = 1'b0;
    chk("chain69", {3'b0, prog_out}, 4'h1);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      prog_en = 1'b1;
      prog_in = 1'b1;
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    prog_en = 1'b0;
    in1 = 4'hF; in2 = 4'hF; in3 = 4'hF; in4 = 4'hF;
    #1;
    chk("mid_o1", out1, 4'h0);
    chk("mid_o3", out3, 4'h0);
    chk("mid_po", {3'b0, prog_out}, 4'h0);

    // random loads against the model
    for (int it = 0; it < 10; it++) begin
      do_reset();
      prog = {$urandom, $urandom, $urandom};
      prog[7:0] = 8'hAA;
      load(prog);
      for (int k = 0; k < 8; k++) begin
        in1 = 4'($urandom); in2 = 4'($urandom);
        in3 = 4'($urandom); in4 = 4'($urandom);
        check_model("rnd_c");
        tick();
        check_model("rnd_r");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
